// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard controller: stall/flush/redirect FSM with wait timeout and stall counter
module pipe_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_pause,
    input  logic [1:0]      id_kind,
    input  logic            ex_resolve,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            mem_ready,
    input  logic            ext_hold,
    input  logic            cnt_clr,
    output logic            pc_stall,
    output logic            if_id_stall,
    output logic            id_ex_flush,
    output logic            if_id_flush,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_load_addr,
    output logic            timeout_err,
    output logic [15:0]     stall_cnt
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_WAIT_EX  = 2'd1,
        S_WAIT_MEM = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    localparam logic [1:0] KIND_NONE = 2'b00;
    localparam logic [1:0] KIND_LOAD = 2'b11;
    localparam logic [3:0] TIMER_MAX = 4'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] timer;
    logic       in_wait;
    logic       ex_done;
    logic       mem_done;
    logic       resolved;
    logic       expired;

    always_comb begin
        in_wait  = (state == S_WAIT_EX) || (state == S_WAIT_MEM);
        ex_done  = (state == S_WAIT_EX) && ex_resolve;
        mem_done = (state == S_WAIT_MEM) && mem_ready;
        resolved = ex_done || mem_done;
        // Resolution in the last allowed cycle wins over the timeout.
        expired  = in_wait && !resolved && (timer == TIMER_MAX);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (id_pause) begin
                    if (id_kind == KIND_LOAD)
                        state_nxt = S_WAIT_MEM;
                    else if (id_kind != KIND_NONE)
                        state_nxt = S_WAIT_EX;
                end else if (ext_hold) begin
                    state_nxt = S_HALT;
                end
            end
            S_WAIT_EX,
            S_WAIT_MEM: begin
                if (resolved || expired)
                    state_nxt = S_RUN;
            end
            S_HALT: begin
                if (!ext_hold)
                    state_nxt = S_RUN;
            end
            default: state_nxt = S_RUN;
        endcase
    end

    always_comb begin
        if (state != S_RUN)
            pc_stall = !resolved;
        else
            pc_stall = id_pause && (id_kind != KIND_NONE);
        if_id_stall  = pc_stall;
        id_ex_flush  = (state != S_RUN);
        pc_load      = ex_done && ex_taken;
        if_id_flush  = pc_load;
        pc_load_addr = pc_load ? ex_target : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RUN;
            timer       <= '0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nxt;

            // Timer restarts on every wait entry and counts only while staying put.
            if (in_wait && (state_nxt == state))
                timer <= timer + 4'd1;
            else
                timer <= '0;

            if (expired)
                timeout_err <= 1'b1;

            if (cnt_clr)
                stall_cnt <= '0;
            else if (pc_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a cycle model
module tb_pipe_ctrl;

    localparam int XLEN = 32;
    localparam int TO   = 8;

    localparam int M_RUN = 0;
    localparam int M_BR  = 1;
    localparam int M_LD  = 2;
    localparam int M_DBG = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            id_pause = 1'b0;
    logic [1:0]      id_kind = 2'b00;
    logic            ex_resolve = 1'b0;
    logic            ex_taken = 1'b0;
    logic [XLEN-1:0] ex_target = '0;
    logic            mem_ready = 1'b0;
    logic            ext_hold = 1'b0;
    logic            cnt_clr = 1'b0;
    logic            pc_stall;
    logic            if_id_stall;
    logic            id_ex_flush;
    logic            if_id_flush;
    logic            pc_load;
    logic [XLEN-1:0] pc_load_addr;
    logic            timeout_err;
    logic [15:0]     stall_cnt;

    int tests = 0;
    int fails = 0;
    bit armed = 1'b0;

    int m_mode = M_RUN;
    int m_left = 0;
    int m_err  = 0;
    int m_cnt  = 0;
    int n_mode = M_RUN;
    int n_left = 0;
    int n_err  = 0;
    int n_cnt  = 0;

    pipe_ctrl #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .id_pause(id_pause), .id_kind(id_kind),
        .ex_resolve(ex_resolve), .ex_taken(ex_taken), .ex_target(ex_target),
        .mem_ready(mem_ready), .ext_hold(ext_hold), .cnt_clr(cnt_clr),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_flush(id_ex_flush),
        .if_id_flush(if_id_flush), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .timeout_err(timeout_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_pause = 0; id_kind = 0; ex_resolve = 0; ex_taken = 0; ex_target = 0;
        mem_ready = 0; ext_hold = 0; cnt_clr = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pc_stall"}, 32'(pc_stall), 0);
        chk({tag, "_if_id_stall"}, 32'(if_id_stall), 0);
        chk({tag, "_id_ex_flush"}, 32'(id_ex_flush), 0);
        chk({tag, "_if_id_flush"}, 32'(if_id_flush), 0);
        chk({tag, "_pc_load"}, 32'(pc_load), 0);
        chk({tag, "_pc_load_addr"}, pc_load_addr, 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
    endtask

    // Model: mode plus cycles-left budget; outputs derived from the rules, compared mid-cycle.
    always @(negedge clk) begin : model_cmp
        bit e_res, e_stall, e_load;
        e_res   = (m_mode == M_BR && ex_resolve) || (m_mode == M_LD && mem_ready);
        e_stall = (m_mode != M_RUN) ? !e_res : (id_pause && id_kind != 2'b00);
        e_load  = (m_mode == M_BR) && ex_resolve && ex_taken;
        if (armed) begin
            chk("cyc_pc_stall", 32'(pc_stall), 32'(e_stall));
            chk("cyc_if_id_stall", 32'(if_id_stall), 32'(e_stall));
            chk("cyc_id_ex_flush", 32'(id_ex_flush), 32'(m_mode != M_RUN));
            chk("cyc_if_id_flush", 32'(if_id_flush), 32'(e_load));
            chk("cyc_pc_load", 32'(pc_load), 32'(e_load));
            chk("cyc_pc_load_addr", pc_load_addr, e_load ? ex_target : 32'h0);
            chk("cyc_timeout_err", 32'(timeout_err), 32'(m_err));
            chk("cyc_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end
        n_mode = m_mode; n_left = m_left; n_err = m_err;
        case (m_mode)
            M_RUN: begin
                if (id_pause) begin
                    if (id_kind == 2'b11) n_mode = M_LD;
                    else if (id_kind != 2'b00) n_mode = M_BR;
                    n_left = TO;
                end else if (ext_hold) begin
                    n_mode = M_DBG;
                end
            end
            M_BR, M_LD: begin
                if (e_res) n_mode = M_RUN;
                else if (m_left == 1) begin n_mode = M_RUN; n_err = 1; end
                else n_left = m_left - 1;
            end
            default: if (!ext_hold) n_mode = M_RUN;
        endcase
        if (cnt_clr) n_cnt = 0;
        else if (e_stall) n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        else n_cnt = m_cnt;
        if (!rst_n) begin n_mode = M_RUN; n_left = 0; n_err = 0; n_cnt = 0; end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= M_RUN; m_left <= 0; m_err <= 0; m_cnt <= 0;
        end else begin
            m_mode <= n_mode; m_left <= n_left; m_err <= n_err; m_cnt <= n_cnt;
        end
    end

    initial begin
        #1 rst_n = 0;
        #2 check_zero("reset");
        #5 rst_n = 1;
        armed = 1;
        cyc();

        // Taken branch: pause cycle plus two unresolved WAIT_EX cycles, resolve on the third.
        id_pause = 1; id_kind = 2'b10;
        #1 chk("br_stall_run", 32'(pc_stall), 1);
        chk("br_flush_run", 32'(id_ex_flush), 0);
        cyc(); idle();
        cyc();
        cyc();
        ex_resolve = 1; ex_taken = 1; ex_target = 32'h80;
        #1 chk("br_pc_load", 32'(pc_load), 1);
        chk("br_addr", pc_load_addr, 32'h80);
        chk("br_if_id_flush", 32'(if_id_flush), 1);
        chk("br_stall_resolve", 32'(pc_stall), 0);
        cyc(); idle();
        #1 chk("br_stall_cnt", 32'(stall_cnt), 3);
        chk("br_back_run", 32'(id_ex_flush), 0);

        // Resolve/ready inputs are ignored in RUN.
        ex_resolve = 1; ex_taken = 1; ex_target = 32'h44; mem_ready = 1;
        #1 chk("run_ignore_load", 32'(pc_load), 0);
        chk("run_ignore_addr", pc_load_addr, 0);
        cyc(); idle();

        // Load: three WAIT_MEM cycles, data on the third.
        id_pause = 1; id_kind = 2'b11;
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) mem_ready = 1;
            #1 chk("ld_flush", 32'(id_ex_flush), 1);
            chk("ld_no_load", 32'(pc_load), 0);
            cyc();
        end
        idle();
        #1 chk("ld_back_run", 32'(id_ex_flush), 0);

        // Timeout: jump never resolves.
        id_pause = 1; id_kind = 2'b01;
        cyc(); idle();
        for (int i = 0; i < TO; i++) begin
            #1 chk("to_in_wait", 32'(id_ex_flush), 1);
            chk("to_err_low", 32'(timeout_err), 0);
            cyc();
        end
        #1 chk("to_back_run", 32'(id_ex_flush), 0);
        chk("to_err_set", 32'(timeout_err), 1);
        cyc(); cyc();
        chk("to_err_sticky", 32'(timeout_err), 1);

        // Pause and hold together: branch first, then HALT, then release.
        id_pause = 1; id_kind = 2'b10; ext_hold = 1;
        cyc(); id_pause = 0; id_kind = 0;
        #1 chk("sim_wait_ex", 32'(id_ex_flush), 1);
        cyc();
        ex_resolve = 1;
        #1 chk("sim_not_taken", 32'(pc_load), 0);
        cyc(); ex_resolve = 0;
        #1 chk("sim_run", 32'(id_ex_flush), 0);
        chk("sim_run_stall", 32'(pc_stall), 0);
        cyc();
        #1 chk("sim_halt", 32'(id_ex_flush), 1);
        chk("sim_halt_stall", 32'(pc_stall), 1);
        cyc(); ext_hold = 0;
        #1 chk("sim_halt_last", 32'(id_ex_flush), 1);
        cyc();
        #1 chk("sim_release", 32'(id_ex_flush), 0);

        // Reset in the middle of a load wait with five stalls counted.
        cnt_clr = 1; cyc(); cnt_clr = 0;
        id_pause = 1; id_kind = 2'b11;
        cyc(); idle();
        repeat (4) cyc();
        chk("rst_pre_cnt", 32'(stall_cnt), 5);
        #2 rst_n = 0;
        #1 check_zero("rst_mid");
        #4 rst_n = 1;
        cyc();
        chk("rst_resume_run", 32'(id_ex_flush), 0);

        // Saturation via a long HALT.
        ext_hold = 1;
        cyc();
        repeat (65534) cyc();
        chk("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        cyc();
        chk("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        cyc(); cyc();
        chk("sat_hold", 32'(stall_cnt), 32'hFFFF);
        cnt_clr = 1;
        cyc();
        chk("sat_clr", 32'(stall_cnt), 0);
        idle();
        cyc(); cyc();

        armed = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter XLEN, default 32, shall set the data and address width.
REQ-002 Parameter TIMEOUT, default 8, shall set the maximum wait cycles in a wait state (range 2..15).
REQ-003 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  shall be the asynchronous, active-low reset.
REQ-005 id_pause  input  1  shall be the pause request from the decode stage for the instruction currently in ID.
REQ-006 id_kind  input  2  shall give the paused instruction class: 00 none, 01 jump (JAL/JALR), 10 branch, 11 load.
REQ-007 ex_resolve  input  1  shall mean execute has resolved the control transfer this cycle.
REQ-008 ex_taken  input  1  shall mean the resolved transfer redirects the PC; valid only with ex_resolve.
REQ-009 ex_target  input  XLEN  shall be the redirect address; valid only with ex_resolve.
REQ-010 mem_ready  input  1  shall mean load data has returned this cycle.
REQ-011 ext_hold  input  1  shall be the external (debug) halt request.
REQ-012 cnt_clr  input  1  shall synchronously clear the stall counter.
REQ-013 pc_stall  output  1  shall hold the PC register.
REQ-014 if_id_stall  output  1  shall hold the IF/ID register.
REQ-015 id_ex_flush  output  1  shall inject a bubble into ID/EX.
REQ-016 if_id_flush  output  1  shall invalidate the IF/ID register.
REQ-017 pc_load  output  1  shall load pc_load_addr into the PC.
REQ-018 pc_load_addr  output  XLEN  shall be the redirect address.
REQ-019 timeout_err  output  1  shall be the sticky wait-timeout flag.
REQ-020 stall_cnt  output  16  shall count stalled cycles.

Function
REQ-021 The FSM shall have exactly four states: RUN, WAIT_EX, WAIT_MEM, HALT.
REQ-022 In RUN with id_pause=1, next state shall be WAIT_MEM for id_kind=11, WAIT_EX for id_kind 01/10, and RUN for id_kind=00.
REQ-023 In RUN with id_pause=0 and ext_hold=1, next state shall be HALT; id_pause shall win when both are asserted.
REQ-024 ext_hold shall be ignored outside RUN and HALT, and shall take effect after return to RUN.
REQ-025 In HALT, next state shall be RUN in the cycle after ext_hold is sampled low.
REQ-026 In WAIT_EX with ex_resolve=1, next state shall be RUN.
REQ-027 In WAIT_EX with ex_resolve=1 and ex_taken=1, the same cycle shall assert pc_load=1, pc_load_addr=ex_target and if_id_flush=1 (combinational, zero latency).
REQ-028 Outside REQ-027, pc_load and if_id_flush shall be 0 and pc_load_addr shall be 0.
REQ-029 In WAIT_MEM with mem_ready=1, next state shall be RUN.
REQ-030 pc_stall and if_id_stall shall be asserted under any of: (state≠RUN) or (state=RUN and id_pause=1 and id_kind≠00), except that they shall deassert in the resolving cycle of REQ-026/REQ-029.
REQ-031 id_ex_flush shall be 1 in WAIT_EX, WAIT_MEM and HALT, and 0 in RUN.
REQ-032 A 4-bit wait timer shall clear on entry to a wait state and increment each cycle the FSM remains there.
REQ-033 When the timer reaches TIMEOUT-1 without resolution, next state shall be RUN and timeout_err shall set; no pc_load shall be issued.
REQ-034 timeout_err shall stay set until reset.
REQ-035 Resolution and timeout in the same cycle shall be treated as resolution, leaving timeout_err unchanged.
REQ-036 stall_cnt shall increment by 1 in each cycle pc_stall=1 and shall saturate at 0xFFFF.
REQ-037 cnt_clr shall override the increment and set stall_cnt to 0.
REQ-038 Inputs ex_resolve and mem_ready shall be ignored in states other than WAIT_EX and WAIT_MEM respectively.

Reset
REQ-039 rst_n=0 shall immediately force state=RUN, timer=0, timeout_err=0 and stall_cnt=0, including mid-wait.
REQ-040 With rst_n=0 and all inputs 0, every output shall read 0.

Verification
REQ-041 Taken branch: RUN, id_pause=1/id_kind=10 -> stalls asserted; 2 cycles later ex_resolve=1, ex_taken=1, ex_target=0x80 -> pc_load=1, pc_load_addr=0x80, if_id_flush=1 that cycle; RUN next; stall_cnt=3.
REQ-042 Load: id_kind=11, mem_ready after 3 cycles -> id_ex_flush=1 for 3 cycles, no pc_load, return to RUN.
REQ-043 Timeout: id_kind=01, ex_resolve held 0 -> RUN after TIMEOUT cycles in WAIT_EX, timeout_err=1 sticky.
REQ-044 Simultaneous: id_pause=1 (kind 10) and ext_hold=1 -> WAIT_EX first; after resolve, HALT; release -> RUN.
REQ-045 Reset mid-WAIT_MEM with stall_cnt=5 -> all outputs 0 asynchronously; resume in RUN.
REQ-046 Saturation: preload stall_cnt to 0xFFFE, stall 3 cycles -> 0xFFFF; cnt_clr=1 -> 0.
